// File: rtl/key_schedule_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_controller_if
// Brief    : Request, status and round-key read bundle for the AES-128 key
//            schedule sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface key_schedule_controller_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [3:0]   rounds_avail;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    modport master (
        output start, key, rk_rd_idx,
        input  busy, done, rounds_avail, rk_rd_data
    );

    modport slave (
        input  start, key, rk_rd_idx,
        output busy, done, rounds_avail, rk_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/key_schedule_controller.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_controller
// Brief    : Iterative AES-128 key expansion (one S-box byte or one word per
//            cycle) into an 11 x 128 round-key bank with a registered read port.
// Revision : 1.0  initial release
// ============================================================================
module key_schedule_controller #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_INIT  = 8'h01
) (
    input wire clk,
    input wire reset,
    key_schedule_controller_if.slave ks
);

    localparam int         c_nwords     = 4 * (NUM_ROUNDS + 1);
    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    localparam logic [0:2047] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_GEN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_busy;
    logic         w_done;

    logic [3:0]   r_round;
    logic [1:0]   r_cnt;
    logic [7:0]   r_rcon;
    logic [31:0]  r_temp;
    logic [31:0]  r_win [0:3];
    logic [3:0]   r_avail;
    logic [127:0] r_rd_data;
    logic [31:0]  r_bank [0:c_nwords-1];

    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;
    logic [31:0]  w_new_word;
    logic [5:0]   w_wr_idx;
    logic [5:0]   w_rd_base;
    logic         w_load;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ks.start) begin
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                w_busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                w_busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = (r_round == c_last_round) ? S_DONE : S_SUB;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared datapath: RotWord byte select, S-box, word XOR
    // ------------------------------------------------------------------
    always_comb begin
        w_sbox_in = r_win[3][31:24];
        case (r_cnt)
            2'd0: w_sbox_in = r_win[3][23:16];
            2'd1: w_sbox_in = r_win[3][15:8];
            2'd2: w_sbox_in = r_win[3][7:0];
            2'd3: w_sbox_in = r_win[3][31:24];
            default: w_sbox_in = r_win[3][31:24];
        endcase
    end

    assign w_sbox_out = c_sbox[{w_sbox_in, 3'b000} +: 8];

    // r_win holds w[4r-4..4r-1]; entries are replaced in place, so r_win[j-1]
    // already carries w[4r+j-1] when word j is formed.
    assign w_new_word = (r_cnt == 2'd0) ? (r_temp ^ {r_rcon, 24'h0} ^ r_win[0])
                                        : (r_win[r_cnt - 2'd1] ^ r_win[r_cnt]);
    assign w_wr_idx   = {r_round, r_cnt};
    assign w_rd_base  = {ks.rk_rd_idx, 2'b00};
    assign w_load     = (r_state == S_IDLE) && ks.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_round   <= 4'd0;
            r_cnt     <= 2'd0;
            r_rcon    <= RCON_INIT;
            r_temp    <= 32'h0;
            r_avail   <= 4'd0;
            r_rd_data <= 128'h0;
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= 32'h0;
            end
        end else begin
            if (w_load) begin
                for (int i = 0; i < 4; i++) begin
                    r_win[i] <= ks.key[127 - 32*i -: 32];
                end
                r_avail <= 4'd1;
                r_round <= 4'd1;
                r_cnt   <= 2'd0;
                r_rcon  <= RCON_INIT;
            end else if (r_state == S_SUB) begin
                r_temp <= {r_temp[23:0], w_sbox_out};
                r_cnt  <= r_cnt + 2'd1;
            end else if (r_state == S_GEN) begin
                r_win[r_cnt] <= w_new_word;
                r_cnt        <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_avail <= r_round + 4'd1;
                    if (r_round != c_last_round) begin
                        r_round <= r_round + 4'd1;
                        r_rcon  <= xtime(r_rcon);
                    end
                end
            end

            // Gating on r_avail hides partially written round keys.
            if (ks.rk_rd_idx < r_avail) begin
                r_rd_data <= {r_bank[w_rd_base],         r_bank[w_rd_base + 6'd1],
                              r_bank[w_rd_base + 6'd2],  r_bank[w_rd_base + 6'd3]};
            end else begin
                r_rd_data <= 128'h0;
            end
        end
    end

    // Bank has no reset; validity is tracked solely by r_avail.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < 4; i++) begin
                r_bank[i] <= ks.key[127 - 32*i -: 32];
            end
        end else if (r_state == S_GEN) begin
            r_bank[w_wr_idx] <= w_new_word;
        end
    end

    assign ks.busy         = w_busy;
    assign ks.done         = w_done;
    assign ks.rounds_avail = r_avail;
    assign ks.rk_rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_controller
// Brief    : Randomized self-checking bench for key_schedule_controller against
//            a FIPS-197 style key expansion and timeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_schedule_controller;

    logic clk = 1'b0;
    logic reset;

    key_schedule_controller_if ks_if();

    key_schedule_controller dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks_if)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;
    int done_seen  = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] m_keys   [0:10];
    logic [3:0]   m_avail;
    int           m_t;   // cycles since the accepted start, -1 when idle

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One clock cycle: drive inputs, advance the model, check at the next negedge.
    task automatic tick(input logic st, input logic [127:0] k, input logic [3:0] idx, input logic rs);
        logic [127:0] exp_rd = 128'h0;
        ks_if.start     = st;
        ks_if.key       = k;
        ks_if.rk_rd_idx = idx;
        reset           = rs;
        if (idx < m_avail) exp_rd = m_keys[idx];
        if (rs) begin
            m_t     = -1;
            m_avail = 4'd0;
            exp_rd  = 128'h0;
        end else if (m_t < 0) begin
            if (st) begin
                expand(k);
                m_t     = 1;
                m_avail = 4'd1;
            end
        end else begin
            if (m_t % 8 == 0 && m_t <= 80) m_avail = 4'(m_t / 8 + 1);
            m_t = (m_t == 81) ? -1 : m_t + 1;
        end
        @(posedge clk);
        @(negedge clk);
        if (ks_if.done) done_seen++;
        check_eq("busy",         128'(ks_if.busy),         128'(m_t >= 1 && m_t <= 80));
        check_eq("done",         128'(ks_if.done),         128'(m_t == 81));
        check_eq("rounds_avail", 128'(ks_if.rounds_avail), 128'(m_avail));
        check_eq("rk_rd_data",   ks_if.rk_rd_data,         exp_rd);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: random read index, 1: index 5 every cycle, 2: start pulsed while busy
    task automatic run_key(input logic [127:0] k, input int mode);
        int n = 0;
        logic [3:0] idx;
        idx = (mode == 1) ? 4'd5 : 4'($urandom_range(0, 15));
        tick(1'b1, k, idx, 1'b0);
        done_seen = 0;
        while (!ks_if.done && n < 120) begin
            idx = (mode == 1) ? 4'd5 : 4'($urandom_range(0, 15));
            tick(mode == 2, rand_key(), idx, 1'b0);
            n++;
        end
        check_eq("done_timeout", 128'(ks_if.done), 128'(1));
        check_eq("done_count",   128'(done_seen),  128'(1));
        tick(1'b0, 128'h0, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    initial begin
        logic [127:0] kat_fips1  = 128'ha0fafe1788542cb123a339392a6c7605;
        logic [127:0] kat_fips10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        logic [127:0] kat_zero1  = 128'h62636363626363636263636362636363;
        logic [127:0] kat_zero10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        ks_if.start     = 1'b0;
        ks_if.key       = 128'h0;
        ks_if.rk_rd_idx = 4'd0;
        reset           = 1'b1;
        m_t             = -1;
        m_avail         = 4'd0;
        for (int i = 0; i < 11; i++) m_keys[i] = 128'h0;
        for (int v = 0; v < 256; v++) sbox_tab[v] = sbox_calc(8'(v));

        for (int i = 0; i < 3; i++) tick(1'b0, 128'h0, 4'd0, 1'b1);
        tick(1'b0, 128'h0, 4'd0, 1'b0);

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        tick(1'b0, 128'h0, 4'd1, 1'b0);
        check_eq("kat_fips_r1", ks_if.rk_rd_data, kat_fips1);
        tick(1'b0, 128'h0, 4'd10, 1'b0);
        check_eq("kat_fips_r10", ks_if.rk_rd_data, kat_fips10);
        for (int i = 11; i < 16; i++) begin
            tick(1'b0, 128'h0, 4'(i), 1'b0);
            check_eq("idx_oob", ks_if.rk_rd_data, 128'h0);
        end

        run_key(128'h0, 0);
        tick(1'b0, 128'h0, 4'd1, 1'b0);
        check_eq("kat_zero_r1", ks_if.rk_rd_data, kat_zero1);
        tick(1'b0, 128'h0, 4'd10, 1'b0);
        check_eq("kat_zero_r10", ks_if.rk_rd_data, kat_zero10);

        // back-to-back runs
        run_key(rand_key(), 0);
        run_key(rand_key(), 0);
        // idx 5 every cycle
        run_key(rand_key(), 1);
        // start pulsed throughout busy
        run_key(rand_key(), 2);

        // reset in the middle of expansion, then a fresh run
        tick(1'b1, rand_key(), 4'd0, 1'b0);
        for (int i = 0; i < 39; i++) tick(1'b0, 128'h0, 4'($urandom_range(0, 10)), 1'b0);
        tick(1'b0, 128'h0, 4'd0, 1'b1);
        tick(1'b0, 128'h0, 4'd0, 1'b0);
        check_eq("post_reset_avail", 128'(ks_if.rounds_avail), 128'(0));
        run_key(rand_key(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
